// File: rtl/keypad_matrix_emulator.sv
// Emulated 4x4 keypad: answers the scanner's active-low column strobes on the
// row lines as if one key were pressed, with timed bounce, hold and release gap.
module keypad_matrix_emulator #(
    parameter int HOLD_W        = 24,
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_PERIOD = 8,
    parameter int GAP_CYCLES    = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_code_i,
    input  logic [HOLD_W-1:0] req_hold_i,
    input  logic [3:0]        col_i,
    output logic [3:0]        row_o,
    output logic              pressed_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_MAX = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int PW      = (BOUNCE_PERIOD < 2) ? 1 : $clog2(BOUNCE_PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_B,
        HOLD,
        REL_B,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        idx_q, idx_d;
    logic              pressed_q, pressed_d;
    logic              done_q, done_d;
    logic [3:0]        row_q;

    assign req_ready_o = rst & (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign pressed_o   = pressed_q;
    assign done_o      = done_q;
    assign row_o       = row_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        hcnt_d    = hcnt_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        pressed_d = pressed_q;
        done_d    = 1'b0;

        // Bounce states share the period toggle; the exit branch below overrides it.
        if (state_q == PRESS_B || state_q == REL_B) begin
            cnt_d = cnt_q + CW'(1);
            if (ph_q == PW'(BOUNCE_PERIOD - 1)) begin
                ph_d      = '0;
                pressed_d = ~pressed_q;
            end else begin
                ph_d = ph_q + PW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    idx_d     = (req_code_i == 4'd0) ? 4'd15 : req_code_i - 4'd1;
                    hold_d    = (req_hold_i == '0) ? HOLD_W'(1) : req_hold_i;
                    pressed_d = 1'b1;
                    cnt_d     = '0;
                    ph_d      = '0;
                    hcnt_d    = HOLD_W'(1);
                    state_d   = (BOUNCE_CYCLES > 0) ? PRESS_B : HOLD;
                end
            end
            PRESS_B: begin
                if (cnt_q == CW'(BOUNCE_CYCLES - 1)) begin
                    state_d   = HOLD;
                    pressed_d = 1'b1;
                    hcnt_d    = HOLD_W'(1);
                    cnt_d     = '0;
                end
            end
            HOLD: begin
                // Equality compare lets an all-ones hold run its full length.
                if (hcnt_q == hold_q) begin
                    pressed_d = 1'b0;
                    cnt_d     = '0;
                    ph_d      = '0;
                    if (BOUNCE_CYCLES > 0) begin
                        state_d = REL_B;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + HOLD_W'(1);
                end
            end
            REL_B: begin
                if (cnt_q == CW'(BOUNCE_CYCLES - 1)) begin
                    pressed_d = 1'b0;
                    cnt_d     = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ph_q      <= '0;
            hcnt_q    <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            pressed_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            hcnt_q    <= hcnt_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            pressed_q <= pressed_d;
            done_q    <= done_d;
        end
    end

    // Matrix physics: the key only shorts its row while its own column is strobed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= 4'b1111;
        end else if (pressed_q && !col_i[idx_q[3:2]]) begin
            row_q <= ~(4'b0001 << idx_q[1:0]);
        end else begin
            row_q <= 4'b1111;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench: one instance without bounce (short hold width), one with
// bounce, both with a short gap so whole presses fit in a few dozen cycles.
module tb_keypad_matrix_emulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       nb_valid = 1'b0, nb_ready;
    logic [3:0] nb_code = 4'd0;
    logic [4:0] nb_hold = 5'd0;
    logic [3:0] nb_col = 4'b1111, nb_row;
    logic       nb_pressed, nb_busy, nb_done;

    logic       b_valid = 1'b0, b_ready;
    logic [3:0] b_code = 4'd0;
    logic [7:0] b_hold = 8'd0;
    logic [3:0] b_col = 4'b1111, b_row;
    logic       b_pressed, b_busy, b_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(
        .HOLD_W(5), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .GAP_CYCLES(8)
    ) u_nb (
        .clk(clk), .rst(rst),
        .req_valid_i(nb_valid), .req_ready_o(nb_ready), .req_code_i(nb_code),
        .req_hold_i(nb_hold), .col_i(nb_col), .row_o(nb_row),
        .pressed_o(nb_pressed), .busy_o(nb_busy), .done_o(nb_done)
    );

    keypad_matrix_emulator #(
        .HOLD_W(8), .BOUNCE_CYCLES(16), .BOUNCE_PERIOD(4), .GAP_CYCLES(8)
    ) u_b (
        .clk(clk), .rst(rst),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_code_i(b_code),
        .req_hold_i(b_hold), .col_i(b_col), .row_o(b_row),
        .pressed_o(b_pressed), .busy_o(b_busy), .done_o(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge; the target must be idle.
    task automatic press(input bit which, input logic [3:0] code, input logic [7:0] hold);
        if (which) begin
            b_code = code; b_hold = hold; b_valid = 1'b1;
        end else begin
            nb_code = code; nb_hold = hold[4:0]; nb_valid = 1'b1;
        end
        tick();
        b_valid  = 1'b0;
        nb_valid = 1'b0;
    endtask

    // Runs exactly `limit` cycles: counts non-idle row samples, the first one,
    // and the cycle index of the first done pulse (-1 if none).
    task automatic observe(input bit which, input int limit, output int act, output int first,
                           output logic [3:0] fval, output int dn);
        logic [3:0] r;
        logic       d;
        act = 0; first = -1; fval = 4'hf; dn = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            r = which ? b_row : nb_row;
            d = which ? b_done : nb_done;
            if (r != 4'b1111) begin
                act++;
                if (first < 0) begin
                    first = i;
                    fval  = r;
                end
            end
            if (d && dn < 0) dn = i;
        end
    endtask

    int         act, first, dn, found;
    logic [3:0] fval, exp_row;
    logic [3:0] codes [3];

    initial begin
        codes[0] = 4'ha; codes[1] = 4'h0; codes[2] = 4'hf;

        // Reset
        repeat (3) tick();
        check("rst_row", nb_row, 4'b1111);
        check("rst_ready", nb_ready, 1'b0);
        check("rst_busy", nb_busy, 1'b0);
        check("rst_pressed", nb_pressed, 1'b0);
        check("rst_done", nb_done, 1'b0);
        check("rst_b_row", b_row, 4'b1111);
        rst = 1'b1;
        tick();
        check("ready_after_rst", nb_ready, 1'b1);
        check("b_ready_after_rst", b_ready, 1'b1);

        // Map: code 6 -> c1,r1
        nb_col = 4'b1101;
        press(1'b0, 4'd6, 8'd20);
        check("map_busy", nb_busy, 1'b1);
        check("map_pressed", nb_pressed, 1'b1);
        check("map_ready_busy", nb_ready, 1'b0);
        check("map_row_lag", nb_row, 4'b1111);
        observe(1'b0, 40, act, first, fval, dn);
        check("map_low_cycles", act, 20);
        check("map_first", first, 1);
        check("map_row", fval, 4'b1101);
        check("map_done_at", dn, 28);

        // Wrong column selected: key invisible
        nb_col = 4'b1110;
        press(1'b0, 4'd6, 8'd10);
        observe(1'b0, 30, act, first, fval, dn);
        check("wrongcol_act", act, 0);
        check("wrongcol_done_at", dn, 18);

        // Hold 0 behaves as hold 1
        press(1'b0, 4'd1, 8'd0);
        observe(1'b0, 20, act, first, fval, dn);
        check("hold0_act", act, 1);
        check("hold0_row", fval, 4'b1110);
        check("hold0_done_at", dn, 9);

        // Hold all-ones counted fully
        nb_col = 4'b0111;
        press(1'b0, 4'd0, 8'd31);
        observe(1'b0, 50, act, first, fval, dn);
        check("holdmax_act", act, 31);
        check("holdmax_row", fval, 4'b0111);
        check("holdmax_done_at", dn, 39);

        // Bounce: code 1, 16 cycles at period 4, then stable hold of 5
        b_col = 4'b1110;
        press(1'b1, 4'd1, 8'd5);
        dn = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i <= 21) begin
                if (i <= 16) exp_row = (((i - 1) / 4) % 2 == 0) ? 4'b1110 : 4'b1111;
                else         exp_row = 4'b1110;
                check($sformatf("bounce_row_%0d", i), b_row, exp_row);
            end
            if (b_done && dn < 0) dn = i;
        end
        check("bounce_done_at", dn, 45);

        // Back-to-back with valid held; inputs change while busy
        nb_col = 4'b1110;
        nb_code = 4'd2; nb_hold = 5'd3; nb_valid = 1'b1;
        tick();
        nb_code = 4'd3;
        tick(); tick();
        check("b2b_latched_row", nb_row, 4'b1101);
        check("b2b_ready_busy", nb_ready, 1'b0);
        dn = -1;
        for (int i = 3; i <= 20; i++) begin
            tick();
            if (nb_done && dn < 0) begin
                dn = i;
                break;
            end
        end
        check("b2b_done_at", dn, 11);
        check("b2b_ready_in_done", nb_ready, 1'b1);
        tick();
        nb_valid = 1'b0;
        check("b2b_second_accept", nb_busy, 1'b1);
        check("b2b_done_single", nb_done, 1'b0);
        tick(); tick();
        check("b2b_second_row", nb_row, 4'b1011);
        observe(1'b0, 20, act, first, fval, dn);
        check("b2b_second_done", dn, 9);

        // Closed loop: sweep columns during hold and decode the answering row
        foreach (codes[k]) begin
            nb_col = 4'b1111;
            press(1'b0, codes[k], 8'd12);
            found = -1;
            for (int c = 0; c < 4; c++) begin
                nb_col = ~(4'b0001 << c);
                tick(); tick();
                for (int r = 0; r < 4; r++)
                    if (!nb_row[r] && found < 0) found = (c * 4 + r == 15) ? 0 : c * 4 + r + 1;
            end
            check($sformatf("loop_code_%0h", codes[k]), found, codes[k]);
            observe(1'b0, 20, act, first, fval, dn);
            check($sformatf("loop_done_%0h", codes[k]), dn, 12);
            nb_col = 4'b0000;
            tick();
            check($sformatf("loop_release_%0h", codes[k]), nb_row, 4'b1111);
        end

        // Reset mid-hold: row released without a clock edge, no done afterwards
        b_col = 4'b0111;
        press(1'b1, 4'd0, 8'd40);
        repeat (20) tick();
        check("midrst_row_before", b_row, 4'b0111);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_row_async", b_row, 4'b1111);
        check("midrst_busy", b_busy, 1'b0);
        check("midrst_ready", b_ready, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_ready_after", b_ready, 1'b1);
        observe(1'b1, 80, act, first, fval, dn);
        check("midrst_no_done", dn, -1);
        check("midrst_no_row", act, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
